serial_pattern_tx: RTL and testbench

Serial bit-pattern transmitter: accepts a parallel pattern word through a valid/ready handshake and shifts it out one bit per clock, MSB-first, for a programmable number of repetitions with idle gap cycles between them. It sits upstream of the team's serial 1-1-0 sequence detector and drives that detector's `data_in` as a stimulus and loopback source. It is the transmit end of the same single-bit serial stream.

---
 rtl/serial_pattern_pkg.sv | 7 +
 rtl/serial_pattern_tx.sv | 90 +++++++++
 tb/tb_serial_pattern_tx.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/serial_pattern_pkg.sv
// serial_pattern_pkg: shared state encoding and length clamping for serial_pattern_tx
package serial_pattern_pkg;
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;
  function automatic int clamp_len(input int l, input int w);
    return (l == 0 || l > w) ? w : l;
  endfunction
endpackage

// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: MSB-first serial transmitter of a latched pattern with repetitions and idle gaps
module serial_pattern_tx
  import serial_pattern_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic             abort,
  output logic             data_out,
  output logic             data_valid,
  output logic             frame_start,
  output logic             done,
  output logic             busy
);
  localparam int GW = GAP > 1 ? $clog2(GAP) : 1;
  state_t state;
  logic [WIDTH-1:0] pat_q;
  logic [LEN_W-1:0] len_q, bit_cnt, len_eff;
  logic [CNT_W-1:0] rep_cnt;
  logic [GW-1:0] gap_cnt;
  logic done_pend, cur_bit;
  assign start_ready = state == S_IDLE && !abort;
  assign busy = state != S_IDLE;
  assign len_eff = LEN_W'(clamp_len(int'(len), WIDTH));
  assign cur_bit = |(pat_q & (WIDTH'(1) << bit_cnt));
  // data outputs lag the state by one edge, so done is staged through done_pend
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      pat_q <= '0;
      len_q <= '0;
      bit_cnt <= '0;
      rep_cnt <= '0;
      gap_cnt <= '0;
      done_pend <= 1'b0;
      done <= 1'b0;
      data_out <= 1'b0;
      data_valid <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      done <= done_pend;
      done_pend <= 1'b0;
      data_out <= 1'b0;
      data_valid <= 1'b0;
      frame_start <= 1'b0;
      case (state)
        S_IDLE:
          if (start_valid && start_ready) begin
            pat_q <= pattern;
            len_q <= len_eff;
            bit_cnt <= len_eff - 1'b1;
            rep_cnt <= repeat_cnt;
            state <= S_SEND;
          end
        S_SEND:
          if (abort) state <= S_IDLE;
          else begin
            data_valid <= 1'b1;
            data_out <= cur_bit;
            frame_start <= bit_cnt == len_q - 1'b1;
            if (bit_cnt != '0) bit_cnt <= bit_cnt - 1'b1;
            else if (rep_cnt == '0) begin
              state <= S_IDLE;
              done_pend <= 1'b1;
            end else begin
              rep_cnt <= rep_cnt - 1'b1;
              bit_cnt <= len_q - 1'b1;
              if (GAP > 0) begin
                state <= S_GAP;
                gap_cnt <= GW'(GAP - 1);
              end
            end
          end
        S_GAP:
          if (abort) state <= S_IDLE;
          else if (gap_cnt == '0) state <= S_SEND;
          else gap_cnt <= gap_cnt - 1'b1;
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb_serial_pattern_tx: scoreboard bench driving a GAP=1 and a GAP=0 transmitter with shared stimulus
module tb_serial_pattern_tx;
  typedef struct {int cyc; logic v, b, fs, d;} rec_t;
  logic clk = 0, rst = 1, start_valid = 0, abort = 0, probe = 0, fin = 0;
  logic [7:0] pattern = 0;
  logic [3:0] len = 0, repeat_cnt = 0;
  logic [1:0] dout, dval, fs, dn, rdy, bsy;
  int cyc = 0, errors = 0, checks = 0;
  int hs[2] = '{1, 1};
  int last[2] = '{0, 0};
  rec_t q[2][$];

  serial_pattern_tx #(.GAP(1)) u1 (.clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(rdy[1]),
    .pattern(pattern), .len(len), .repeat_cnt(repeat_cnt), .abort(abort), .data_out(dout[1]),
    .data_valid(dval[1]), .frame_start(fs[1]), .done(dn[1]), .busy(bsy[1]));
  serial_pattern_tx #(.GAP(0)) u0 (.clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(rdy[0]),
    .pattern(pattern), .len(len), .repeat_cnt(repeat_cnt), .abort(abort), .data_out(dout[0]),
    .data_valid(dval[0]), .frame_start(fs[0]), .done(dn[0]), .busy(bsy[0]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string n, logic [5:0] a, logic [5:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", n, a, e);
    end
  endtask

  // expected stream built from the rules: len bits MSB-first per repetition, g zeros between, then done
  task automatic push(int i, int k, int g, logic [7:0] p, int l, int r, output int n);
    int c = k;
    for (int rep = 0; rep <= r; rep++) begin
      for (int bi = l - 1; bi >= 0; bi--) begin
        c++;
        q[i].push_back(rec_t'{c, 1'b1, p[bi], 1'(bi == l - 1), 1'b0});
      end
      if (rep < r)
        for (int j = 0; j < g; j++) begin
          c++;
          q[i].push_back(rec_t'{c, 1'b0, 1'b0, 1'b0, 1'b0});
        end
    end
    c++;
    q[i].push_back(rec_t'{c, 1'b0, 1'b0, 1'b0, 1'b1});
    n = c - k;
    hs[i] = k;
    last[i] = c - 2;
  endtask

  task automatic scramble();
    pattern = 8'($urandom);
    len = 4'($urandom);
    repeat_cnt = 4'($urandom);
  endtask

  task automatic send(logic [7:0] p, logic [3:0] l, logic [3:0] r, int ab);
    int k, n0, n1, e;
    pattern = p;
    len = l;
    repeat_cnt = r;
    start_valid = 1;
    @(posedge clk); #1;
    k = cyc;
    start_valid = 0;
    e = (l == 0 || l > 8) ? 8 : int'(l);
    push(1, k, 1, p, e, int'(r), n1);
    push(0, k, 0, p, e, int'(r), n0);
    if (ab > 0) begin
      repeat (ab - 1) begin scramble(); @(posedge clk); #1; end
      abort = 1;
      for (int i = 0; i < 2; i++) begin
        while (q[i].size() > 0 && q[i][$].cyc >= k + ab) void'(q[i].pop_back());
        last[i] = k + ab - 1;
      end
      @(posedge clk); #1;
      abort = 0;
    end else
      while (cyc < k + n1 - 1) begin scramble(); @(posedge clk); #1; end
  endtask

  always @(negedge clk or posedge probe) begin
    for (int i = 0; i < 2; i++) begin
      rec_t e;
      logic eb;
      e = rec_t'{cyc, 1'b0, 1'b0, 1'b0, 1'b0};
      if (q[i].size() > 0 && q[i][0].cyc == cyc) e = q[i].pop_front();
      eb = cyc >= hs[i] && cyc <= last[i];
      chk($sformatf("out[g%0d]@%0d v,b,fs,done,busy,rdy", i, cyc),
          {dval[i], dout[i], fs[i], dn[i], bsy[i], rdy[i]},
          {e.v, e.b, e.fs, e.d, eb, !eb && !abort});
    end
    if (fin) begin
      for (int i = 0; i < 2; i++) chk($sformatf("leftover[g%0d]", i), 6'(q[i].size()), 6'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int k, n, e, r, ab;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;
    send(8'b0000_0110, 4'd3, 4'd0, 0);
    send(8'hA5, 4'd0, 4'd0, 0);
    send(8'b0000_0110, 4'd3, 4'd2, 0);
    send(8'b0000_0010, 4'd2, 4'd1, 0);
    send(8'h01, 4'd1, 4'd3, 0);
    send(8'hC3, 4'd12, 4'd1, 0);
    send(8'b0000_0110, 4'd3, 4'd0, 3);
    abort = 1;
    start_valid = 1;
    @(posedge clk); #1;
    abort = 0;
    start_valid = 0;
    @(posedge clk); #1;
    pattern = 8'hF0;
    len = 4'd8;
    repeat_cnt = 4'd1;
    start_valid = 1;
    @(posedge clk); #1;
    k = cyc;
    start_valid = 0;
    push(1, k, 1, 8'hF0, 8, 1, n);
    push(0, k, 0, 8'hF0, 8, 1, n);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      q[i].delete();
      last[i] = hs[i] - 1;
    end
    #1 probe = 1;
    #1 begin probe = 0; rst = 0; end
    @(posedge clk); #1;
    send(8'b0000_0110, 4'd3, 4'd1, 0);
    for (int t = 0; t < 40; t++) begin
      logic [7:0] p = 8'($urandom);
      logic [3:0] l = 4'($urandom_range(0, 15));
      r = $urandom_range(0, 3);
      e = (l == 0 || l > 8) ? 8 : int'(l);
      ab = ($urandom_range(0, 3) == 0) ? 1 + $urandom_range(0, e * (r + 1) - 1) : 0;
      send(p, l, 4'(r), ab);
      repeat ($urandom_range(0, 2)) begin scramble(); @(posedge clk); #1; end
    end
    repeat (3) @(posedge clk);
    #1 fin = 1;
  end
endmodule
